// File: rtl/fifo_pkg.sv
// Shared definitions for the 8-bit fifo and its controllers: FSM state
// encoding and a constant-evaluable ceil(log2) helper.
package fifo_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    localparam int unsigned FIFO_DATA_W = 8;
    localparam int unsigned FIFO_CNT_W  = 8;
    localparam int unsigned FIFO_DEPTH  = 64;

    // Bits needed to index n items; 0 for n <= 1.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        int unsigned v;
        r = 0;
        v = (n > 0) ? n - 1 : 0;
        while (v != 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational rotating-priority picker: first asserted request found
// searching upward from i_ptr with wrap to index 0.
module rr_pick #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned IDX_W   = 2
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_ptr,
    output logic [IDX_W-1:0]   o_winner_c,
    output logic               o_any_c
);

    logic [NUM_REQ-1:0] w_rot;
    logic [IDX_W-1:0]   w_off;
    logic [IDX_W:0]     w_sum;

    // Rotate so i_ptr lands at bit 0, take the lowest set bit, rotate back.
    always_comb begin
        w_rot = NUM_REQ'({i_req, i_req} >> i_ptr);
        w_off = '0;
        for (int k = int'(NUM_REQ) - 1; k >= 0; k--) begin
            if (w_rot[k]) begin
                w_off = IDX_W'(k);
            end
        end
        w_sum = {1'b0, i_ptr} + {1'b0, w_off};
        if (w_sum >= (IDX_W+1)'(NUM_REQ)) begin
            w_sum = w_sum - (IDX_W+1)'(NUM_REQ);
        end
    end

    assign o_winner_c = w_sum[IDX_W-1:0];
    assign o_any_c    = |i_req;

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin, burst-bounded arbiter sharing the fifo write port among
// NUM_REQ producers; never issues a write that could overflow the fifo.
module fifo_wr_arbiter
    import fifo_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = FIFO_DATA_W,
    parameter int unsigned CNT_W     = FIFO_CNT_W,
    parameter int unsigned DEPTH     = FIFO_DEPTH,
    parameter int unsigned BURST_MAX = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [NUM_REQ-1:0]          i_req,
    input  logic [NUM_REQ*DATA_W-1:0]   i_req_data,
    input  logic [NUM_REQ-1:0]          i_req_last,
    output logic [NUM_REQ-1:0]          o_gnt_c,
    output logic [clog2(NUM_REQ)-1:0]   o_owner,
    output logic                        o_busy,
    input  logic [CNT_W-1:0]            i_fifo_counter,
    output logic [DATA_W-1:0]           o_buf_in,
    output logic                        o_wr_en
);

    localparam int unsigned OWN_W  = clog2(NUM_REQ);
    localparam int unsigned BCNT_W = clog2(BURST_MAX + 1);

    state_t              r_state;
    logic [OWN_W-1:0]    r_ptr;
    logic [OWN_W-1:0]    r_owner;
    logic [BCNT_W-1:0]   r_burst_cnt;
    logic                r_wr_en;
    logic [DATA_W-1:0]   r_buf_in;

    logic [OWN_W-1:0]    w_winner;
    logic                w_any;
    logic [CNT_W:0]      w_occ;
    logic                w_space;
    logic                w_accept;
    logic                w_burst_end;
    logic                w_exit;
    logic [OWN_W-1:0]    w_ptr_nxt;
    logic [DATA_W-1:0]   w_data_arr [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (OWN_W)
    ) u_rr_pick (
        .i_req      (i_req),
        .i_ptr      (r_ptr),
        .o_winner_c (w_winner),
        .o_any_c    (w_any)
    );

    always_comb begin
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            w_data_arr[i] = i_req_data[i*DATA_W +: DATA_W];
        end
    end

    // A registered write still in flight is not yet in fifo_counter; count it as occupied.
    assign w_occ       = {1'b0, i_fifo_counter} + (CNT_W+1)'(r_wr_en);
    assign w_space     = w_occ < (CNT_W+1)'(DEPTH);
    assign w_accept    = (r_state == ST_GRANT) && i_req[r_owner] && w_space;
    assign w_burst_end = (r_burst_cnt == BCNT_W'(BURST_MAX - 1));
    assign w_exit      = (r_state == ST_GRANT) &&
                         (!i_req[r_owner] || (w_accept && (i_req_last[r_owner] || w_burst_end)));
    assign w_ptr_nxt   = (r_owner == OWN_W'(NUM_REQ - 1)) ? '0 : r_owner + OWN_W'(1);

    assign o_gnt_c  = w_accept ? (NUM_REQ'(1) << r_owner) : '0;
    assign o_owner  = r_owner;
    assign o_busy   = (r_state == ST_GRANT);
    assign o_buf_in = r_buf_in;
    assign o_wr_en  = r_wr_en;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_owner     <= '0;
            r_burst_cnt <= '0;
            r_wr_en     <= 1'b0;
            r_buf_in    <= '0;
        end else begin
            r_wr_en <= w_accept;
            if (w_accept) begin
                r_buf_in    <= w_data_arr[r_owner];
                r_burst_cnt <= r_burst_cnt + BCNT_W'(1);
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_any) begin
                        r_owner     <= w_winner;
                        r_burst_cnt <= '0;
                        r_state     <= ST_GRANT;
                    end
                end
                ST_GRANT: begin
                    if (w_exit) begin
                        r_ptr   <= w_ptr_nxt;
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Bench for fifo_wr_arbiter: directed scenarios plus random traffic against
// a transaction-level model of grants, fifo occupancy and word order.
module tb_fifo_wr_arbiter;

    localparam int N     = 4;
    localparam int DEPTH = 64;
    localparam int BMAX  = 4;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  last;
    logic [3:0]  gnt;
    logic [1:0]  owner;
    logic        busy;
    logic [7:0]  fifo_counter;
    logic [7:0]  buf_in;
    logic        wr_en;

    fifo_wr_arbiter #(
        .NUM_REQ   (4),
        .DATA_W    (8),
        .CNT_W     (8),
        .DEPTH     (64),
        .BURST_MAX (4)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req          (req),
        .i_req_data     (req_data),
        .i_req_last     (last),
        .o_gnt_c        (gnt),
        .o_owner        (owner),
        .o_busy         (busy),
        .i_fifo_counter (fifo_counter),
        .o_buf_in       (buf_in),
        .o_wr_en        (wr_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks;
    int          n_fail;
    logic [3:0]  s_req;
    logic [3:0]  s_last;
    logic [7:0]  prod_word [4];
    logic [5:0]  exp_seq [4];
    int          rd_pct;
    bit          rand_mode;
    bit          auto_prod;
    bit          order_chk;
    bit          m_busy;
    int          m_owner;
    int          m_ptr;
    int          m_taken;
    bit          m_wr;
    logic [7:0]  m_buf;
    int          m_fifo;
    logic [3:0]  gnt_hist [$];
    logic [7:0]  wr_hist [$];
    bit          wr_flags [$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int rr_model(input logic [3:0] r, input int p);
        for (int k = 0; k < N; k++) begin
            if (r[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_taken = 0;
        m_wr    = 1'b0;
        m_buf   = 8'h00;
    endtask

    task automatic clear_hist();
        gnt_hist.delete();
        wr_hist.delete();
        wr_flags.delete();
    endtask

    // One clock: drive at edge+1, compare at edge+3, advance the model at the edge.
    task automatic run_cycle();
        logic [3:0] eg;
        logic [3:0] g_obs;
        bit         wr_obs;
        bit         acc;
        int         w;
        int         rd;
        if (rand_mode) begin
            for (int i = 0; i < N; i++) begin
                s_req[i]  = ($urandom_range(99) < 70);
                s_last[i] = ($urandom_range(99) < 25);
            end
        end
        req  = s_req;
        last = s_last;
        for (int i = 0; i < N; i++) req_data[i*8 +: 8] = prod_word[i];
        fifo_counter = 8'(m_fifo);
        #2;
        eg = 4'b0;
        if (m_busy && s_req[m_owner] && (m_fifo + int'(m_wr)) < DEPTH) eg[m_owner] = 1'b1;
        check_eq("gnt", 32'(gnt), 32'(eg));
        check_eq("wr_en", 32'(wr_en), 32'(m_wr));
        check_eq("buf_in", 32'(buf_in), 32'(m_buf));
        check_eq("busy", 32'(busy), 32'(m_busy));
        check_eq("owner", 32'(owner), 32'(m_owner));
        g_obs  = gnt;
        wr_obs = wr_en;
        gnt_hist.push_back(g_obs);
        wr_flags.push_back(wr_obs);
        if (wr_obs) wr_hist.push_back(buf_in);
        if (order_chk && wr_obs) begin
            w = int'(buf_in[7:6]);
            check_eq("word_order", 32'(buf_in[5:0]), 32'(exp_seq[w]));
            exp_seq[w] = exp_seq[w] + 6'd1;
        end
        @(posedge clk);
        acc  = (eg != 4'b0);
        m_wr = acc;
        if (acc) m_buf = prod_word[m_owner];
        if (m_busy) begin
            if (!s_req[m_owner] || (acc && (s_last[m_owner] || m_taken == BMAX - 1))) begin
                m_busy = 1'b0;
                m_ptr  = (m_owner + 1) % N;
            end else if (acc) begin
                m_taken++;
            end
        end else begin
            w = rr_model(s_req, m_ptr);
            if (w >= 0) begin
                m_busy  = 1'b1;
                m_owner = w;
                m_taken = 0;
            end
        end
        if (auto_prod) begin
            for (int i = 0; i < N; i++) begin
                if (g_obs[i]) prod_word[i] = {prod_word[i][7:6], prod_word[i][5:0] + 6'd1};
            end
        end
        rd = (m_fifo > 0 && $urandom_range(99) < rd_pct) ? 1 : 0;
        m_fifo = m_fifo + int'(wr_obs) - rd;
        if (wr_obs) check_eq("fifo_bound", 32'(m_fifo <= DEPTH), 32'd1);
        #1;
    endtask

    task automatic run_n(input int n);
        for (int i = 0; i < n; i++) run_cycle();
    endtask

    initial begin
        int cnt;
        logic [3:0] exp_g;
        n_checks  = 0;
        n_fail    = 0;
        rst_n     = 1'b0;
        s_req     = 4'b0;
        s_last    = 4'b0;
        req       = 4'b0;
        last      = 4'b0;
        req_data  = 32'h0;
        fifo_counter = 8'h00;
        rd_pct    = 100;
        rand_mode = 1'b0;
        auto_prod = 1'b1;
        order_chk = 1'b0;
        m_fifo    = 0;
        for (int i = 0; i < N; i++) begin
            prod_word[i] = 8'(i * 16);
            exp_seq[i]   = 6'd0;
        end
        model_reset();

        #2;
        check_eq("rst_gnt", 32'(gnt), 32'h0);
        check_eq("rst_wr_en", 32'(wr_en), 32'h0);
        check_eq("rst_busy", 32'(busy), 32'h0);
        check_eq("rst_buf_in", 32'(buf_in), 32'h0);
        check_eq("rst_owner", 32'(owner), 32'h0);
        #10 rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Round-robin with all requesters active: 4-word bursts separated by an IDLE cycle.
        clear_hist();
        s_req = 4'b1111;
        run_n(25);
        for (int c = 0; c < 25; c++) begin
            exp_g = ((c % 5) == 0) ? 4'b0 : (4'b0001 << ((c / 5) % 4));
            check_eq("rr_seq", 32'(gnt_hist[c]), 32'(exp_g));
        end

        // Asynchronous reset with a write in flight.
        check_eq("pre_rst_wr_en", 32'(wr_en), 32'h1);
        rst_n = 1'b0;
        s_req = 4'b0;
        req   = 4'b0;
        #1;
        check_eq("rst_mid_wr_en", 32'(wr_en), 32'h0);
        check_eq("rst_mid_gnt", 32'(gnt), 32'h0);
        check_eq("rst_mid_busy", 32'(busy), 32'h0);
        check_eq("rst_mid_buf_in", 32'(buf_in), 32'h0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        clear_hist();
        s_req = 4'b0001;
        run_n(4);
        check_eq("rst_first_gnt", 32'(gnt_hist[1]), 32'h1);
        check_eq("rst_wr_lat0", 32'(wr_flags[1]), 32'h0);
        check_eq("rst_wr_lat1", 32'(wr_flags[2]), 32'h1);
        s_req = 4'b0;
        run_n(2);

        // req_last ends a burst early; pointer advances past the owner.
        clear_hist();
        auto_prod    = 1'b0;
        prod_word[2] = 8'hA1;
        s_req        = 4'b0100;
        for (int c = 0; c < 8; c++) begin
            run_cycle();
            if (gnt_hist[$][2]) begin
                if (prod_word[2] == 8'hA1) begin
                    prod_word[2] = 8'hA2;
                    s_last       = 4'b0100;
                end else begin
                    s_req  = 4'b0;
                    s_last = 4'b0;
                end
            end
        end
        check_eq("last_count", 32'(wr_hist.size()), 32'd2);
        if (wr_hist.size() == 2) begin
            check_eq("last_w0", 32'(wr_hist[0]), 32'hA1);
            check_eq("last_w1", 32'(wr_hist[1]), 32'hA2);
        end
        auto_prod = 1'b1;
        s_req     = 4'b1111;
        run_n(2);
        check_eq("last_ptr3", 32'(gnt_hist[$]), 32'h8);
        s_req = 4'b0;
        run_n(3);

        // Full boundary: one word fits, the in-flight write then blocks further grants.
        rd_pct = 0;
        m_fifo = 63;
        clear_hist();
        s_req = 4'b0010;
        run_n(6);
        cnt = 0;
        foreach (gnt_hist[i]) if (gnt_hist[i] != 4'b0) cnt++;
        check_eq("full_one_gnt", 32'(cnt), 32'd1);
        m_fifo = 62;
        clear_hist();
        run_n(1);
        check_eq("full_resume", 32'(gnt_hist[0]), 32'h2);
        s_req = 4'b0;
        run_n(3);

        // Release while stalled on a full fifo: no write, pointer moves on.
        m_fifo = 64;
        clear_hist();
        s_req = 4'b0100;
        run_n(3);
        check_eq("stall_owner", 32'(owner), 32'd2);
        check_eq("stall_busy", 32'(busy), 32'd1);
        s_req = 4'b0;
        run_n(1);
        check_eq("release_idle", 32'(busy), 32'd0);
        s_req = 4'b1000;
        run_n(1);
        check_eq("release_next_owner", 32'(owner), 32'd3);
        check_eq("release_next_busy", 32'(busy), 32'd1);
        cnt = 0;
        foreach (wr_flags[i]) if (wr_flags[i]) cnt++;
        check_eq("release_no_wr", 32'(cnt), 32'd0);
        s_req = 4'b0;
        run_n(2);
        m_fifo = 0;

        // Random traffic with random fifo draining.
        for (int i = 0; i < N; i++) begin
            prod_word[i] = {2'(i), 6'd0};
            exp_seq[i]   = 6'd0;
        end
        rd_pct    = 35;
        order_chk = 1'b1;
        rand_mode = 1'b1;
        run_n(800);
        rand_mode = 1'b0;
        s_req     = 4'b0;
        s_last    = 4'b0;
        run_n(3);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
